// File: rtl/mpi_pkg.sv
// Shared FIFO defaults, arbiter state encoding and the occupancy-cap helper
// used by fifo_wr_arbiter.
package mpi_pkg;
  localparam int FIFO_W = 128;
  localparam int FIFO_D = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // The downstream FIFO counter is d bits wide, so it can hold at most 2**d-1 entries.
  function automatic int occ_cap(input int d);
    return (1 << d) - 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past ptr and wraps; the first
// requester found gets a one-hot grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);
  localparam int IW = $clog2(N);

  int            idx;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + 1 + k) % N;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a FIFO with occupancy tracking.
// Define FIFO_ARB_PKT_LOCK_EN to hold the grant for a whole packet (until req_last).
module fifo_wr_arbiter
  import mpi_pkg::*;
#(
  parameter int N = 4,
  parameter int W = FIFO_W,
  parameter int D = FIFO_D
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic [W-1:0]         fifo_idata,
  output logic                 fifo_ivalid,
  input  logic                 fifo_ovalid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 full,
  output logic [D-1:0]         occupancy,
  output logic                 arb_state
);
  localparam int            IW      = $clog2(N);
  localparam logic [D-1:0]  OCC_CAP = D'(occ_cap(D));

  // Handshake: a beat moves when req_valid[i] && req_ready[i]. req_ready is
  // combinational, one-hot, never high without req_valid, and all-zero while
  // reset is low or the FIFO is full.
  arb_state_t    state;
  logic [N-1:0]  candidates;
  logic [N-1:0]  grant;
  logic          accept;
  logic          pop;
  logic [IW-1:0] accept_id;
  logic [W-1:0]  sel_data;

`ifdef FIFO_ARB_PKT_LOCK_EN
  arb_state_t   state_next;
  logic [N-1:0] lock_mask;

  // While locked, grant_id still names the requester that owns the packet.
  assign lock_mask  = N'(1) << grant_id;
  assign candidates = (state == LOCKED) ? (req_valid & lock_mask) : req_valid;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !req_last[accept_id]) state_next = LOCKED;
      LOCKED:  if (accept &&  req_last[accept_id]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign candidates  = req_valid;
  assign state       = IDLE;
`endif

  assign arb_state = state;

  rr_arbiter #(.N(N)) u_rr (
    .req   (candidates),
    .ptr   (grant_id),
    .grant (grant)
  );

  assign full      = (occupancy == OCC_CAP);
  assign req_ready = (reset && !full) ? grant : '0;
  assign accept    = |req_ready;
  assign pop       = fifo_ovalid && (occupancy != '0);

  always_comb begin
    accept_id = '0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        accept_id = IW'(i);
        sel_data  = req_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fifo_ivalid <= 1'b0;
      fifo_idata  <= '0;
      occupancy   <= '0;
      grant_id    <= IW'(N-1);
    end else begin
      fifo_ivalid <= accept;
      if (accept) begin
        fifo_idata <= sel_data;
        grant_id   <= accept_id;
      end
      case ({accept, pop})
        2'b10:   occupancy <= occupancy + D'(1);
        2'b01:   occupancy <= occupancy - D'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, W=16, D=3); expectations follow
// FIFO_ARB_PKT_LOCK_EN when it is defined for the build.
module tb_fifo_wr_arbiter;
  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [15:0] fifo_idata;
  logic        fifo_ivalid;
  logic        fifo_ovalid;
  logic [1:0]  grant_id;
  logic        full;
  logic [2:0]  occupancy;
  logic        arb_state;

  int total = 0;
  int bad   = 0;

  fifo_wr_arbiter #(.N(4), .W(16), .D(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_idata  (fifo_idata),
    .fifo_ivalid (fifo_ivalid),
    .fifo_ovalid (fifo_ovalid),
    .grant_id    (grant_id),
    .full        (full),
    .occupancy   (occupancy),
    .arb_state   (arb_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset       = 1'b0;
    req_valid   = '0;
    req_last    = '0;
    fifo_ovalid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    req_valid   = 4'b1111;
    req_last    = '0;
    fifo_ovalid = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready_pre got=%b want=0000", req_ready); end
    tick();
    tick();
    total++; if (fifo_ivalid !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b want=0", fifo_ivalid); end
    total++; if (fifo_idata !== 16'h0) begin bad++; $display("FAIL rst_idata got=%h want=0000", fifo_idata); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b want=0", full); end
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL rst_grant got=%0d want=3", grant_id); end
    total++; if (arb_state !== 1'b0) begin bad++; $display("FAIL rst_state got=%b want=0", arb_state); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", req_ready); end
    reset     = 1'b1;
    req_valid = '0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready got=%b want=0000", req_ready); end
  endtask

  task automatic test_round_robin;
    logic [3:0]  exp_ready;
    logic [15:0] exp_data;
    int          exp_id;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id    = k % 4;
      exp_ready = 4'b0001 << exp_id;
      exp_data  = 16'hA000 + 16'(exp_id);
      #1;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, req_ready, exp_ready); end
      tick();
      total++; if (fifo_ivalid !== 1'b1) begin bad++; $display("FAIL rr_ivalid[%0d] got=%b want=1", k, fifo_ivalid); end
      total++; if (fifo_idata !== exp_data) begin bad++; $display("FAIL rr_idata[%0d] got=%h want=%h", k, fifo_idata, exp_data); end
      total++; if (grant_id !== 2'(exp_id)) begin bad++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", k, grant_id, exp_id); end
      total++; if (occupancy !== 3'(k + 1)) begin bad++; $display("FAIL rr_occ[%0d] got=%0d want=%0d", k, occupancy, k + 1); end
    end
    req_valid = '0;
    tick();
    total++; if (fifo_ivalid !== 1'b0) begin bad++; $display("FAIL rr_ivalid_idle got=%b want=0", fifo_ivalid); end
    total++; if (fifo_idata !== 16'hA000) begin bad++; $display("FAIL rr_idata_hold got=%h want=a000", fifo_idata); end
    total++; if (occupancy !== 3'd5) begin bad++; $display("FAIL rr_occ_idle got=%0d want=5", occupancy); end
  endtask

  task automatic test_simultaneous;
    req_valid   = 4'b0100;
    fifo_ovalid = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL sim_ready got=%b want=0100", req_ready); end
    tick();
    total++; if (occupancy !== 3'd5) begin bad++; $display("FAIL sim_occ got=%0d want=5", occupancy); end
    total++; if (fifo_ivalid !== 1'b1) begin bad++; $display("FAIL sim_ivalid got=%b want=1", fifo_ivalid); end
    total++; if (fifo_idata !== 16'hA002) begin bad++; $display("FAIL sim_idata got=%h want=a002", fifo_idata); end
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL sim_grant got=%0d want=2", grant_id); end
    req_valid   = '0;
    fifo_ovalid = 1'b0;
  endtask

  task automatic test_reset_mid_stream;
    fifo_ovalid = 1'b1;
    tick();
    tick();
    fifo_ovalid = 1'b0;
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL mid_pop_occ got=%0d want=3", occupancy); end
    req_valid = 4'b0011;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ready got=%b want=0001", req_ready); end
    tick();
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL mid_occ got=%0d want=4", occupancy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_grant got=%0d want=0", grant_id); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b want=0000", req_ready); end
    tick();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL mid_rst_occ got=%0d want=0", occupancy); end
    total++; if (fifo_ivalid !== 1'b0) begin bad++; $display("FAIL mid_rst_ivalid got=%b want=0", fifo_ivalid); end
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL mid_rst_grant got=%0d want=3", grant_id); end
    total++; if (fifo_idata !== 16'h0) begin bad++; $display("FAIL mid_rst_idata got=%h want=0000", fifo_idata); end
    reset     = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_underflow;
    fifo_ovalid = 1'b1;
    tick();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL uf_occ1 got=%0d want=0", occupancy); end
    tick();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL uf_occ2 got=%0d want=0", occupancy); end
    fifo_ovalid = 1'b0;
  endtask

  task automatic test_full;
    int accepts;
    accepts   = 0;
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready[2] === 1'b1) accepts++;
      tick();
    end
    total++; if (accepts != 7) begin bad++; $display("FAIL full_accepts got=%0d want=7", accepts); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full); end
    total++; if (occupancy !== 3'd7) begin bad++; $display("FAIL full_occ got=%0d want=7", occupancy); end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL full_ready got=%b want=0000", req_ready); end
    fifo_ovalid = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL full_pop_ready got=%b want=0000", req_ready); end
    tick();
    fifo_ovalid = 1'b0;
    total++; if (occupancy !== 3'd6) begin bad++; $display("FAIL full_pop_occ got=%0d want=6", occupancy); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL full_pop_flag got=%b want=0", full); end
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL full_refill_ready got=%b want=0100", req_ready); end
    tick();
    total++; if (occupancy !== 3'd7) begin bad++; $display("FAIL full_refill_occ got=%0d want=7", occupancy); end
    total++; if (fifo_ivalid !== 1'b1) begin bad++; $display("FAIL full_refill_ivalid got=%b want=1", fifo_ivalid); end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL full_again_ready got=%b want=0000", req_ready); end
    tick();
    total++; if (fifo_ivalid !== 1'b0) begin bad++; $display("FAIL full_again_ivalid got=%b want=0", fifo_ivalid); end
    req_valid = '0;
  endtask

  task automatic test_pkt_lock;
    int          exp_seq[4];
    int          r1_beats;
    logic [3:0]  exp_ready;
    logic [15:0] exp_data;
`ifdef FIFO_ARB_PKT_LOCK_EN
    exp_seq = '{1, 1, 1, 0};
`else
    exp_seq = '{1, 0, 1, 0};
`endif
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL pkt_align_ready got=%b want=0001", req_ready); end
    tick();
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL pkt_align_grant got=%0d want=0", grant_id); end
    r1_beats = 0;
    for (int k = 0; k < 4; k++) begin
      req_valid = {2'b00, (r1_beats < 3), 1'b1};
      req_last  = {2'b00, (r1_beats == 2), 1'b1};
      exp_ready = 4'b0001 << exp_seq[k];
      exp_data  = 16'hA000 + 16'(exp_seq[k]);
      #1;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL pkt_ready[%0d] got=%b want=%b", k, req_ready, exp_ready); end
      if (req_ready[1] === 1'b1) r1_beats++;
      tick();
      total++; if (grant_id !== 2'(exp_seq[k])) begin bad++; $display("FAIL pkt_grant[%0d] got=%0d want=%0d", k, grant_id, exp_seq[k]); end
      total++; if (fifo_idata !== exp_data) begin bad++; $display("FAIL pkt_idata[%0d] got=%h want=%h", k, fifo_idata, exp_data); end
    end
    total++; if (occupancy !== 3'd5) begin bad++; $display("FAIL pkt_occ got=%0d want=5", occupancy); end
    total++; if (arb_state !== 1'b0) begin bad++; $display("FAIL pkt_state got=%b want=0", arb_state); end
    req_valid = '0;
    req_last  = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'hA000 + 16'(i);
    reset       = 1'b0;
    req_valid   = '0;
    req_last    = '0;
    fifo_ovalid = 1'b0;
    test_reset();
    test_round_robin();
    test_simultaneous();
    test_reset_mid_stream();
    test_underflow();
    apply_reset();
    test_full();
    apply_reset();
    test_pkt_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter W, default 128, data width, equal to the downstream FIFO n.
REQ-003 SHALL have parameter D, default 8, downstream FIFO address width d.
REQ-004 SHALL have port: clock  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: req_valid  input  N  per-requester beat valid.
REQ-007 SHALL have port: req_data  input  N*W  per-requester beat; slice i is [i*W +: W].
REQ-008 SHALL have port: req_last  input  N  per-requester end-of-packet marker.
REQ-009 SHALL have port: req_ready  output  N  one-hot accept, combinational; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 SHALL have port: fifo_idata  output  W  registered beat to FIFO idata.
REQ-011 SHALL have port: fifo_ivalid  output  1  registered write strobe to FIFO ivalid.
REQ-012 SHALL have port: fifo_ovalid  input  1  FIFO ovalid; one pulse per popped entry.
REQ-013 SHALL have port: grant_id  output  $clog2(N)  index of the last accepted requester.
REQ-014 SHALL have port: full  output  1  high when occupancy equals 2**D-1.
REQ-015 SHALL have port: occupancy  output  D  tracked FIFO entry count.

Function
REQ-016 SHALL accept at most one beat per cycle, and only when occupancy < 2**D-1 (the FIFO counter is D bits wide, so this is the cap).
REQ-017 SHALL choose a requester round-robin: search starts at grant_id+1 modulo N, and the lowest index at or after that position with req_valid high wins.
REQ-018 SHALL, one cycle after an accept, drive fifo_ivalid=1 with fifo_idata equal to the accepted beat; in all other cycles it SHALL drive fifo_ivalid=0 and hold fifo_idata.
REQ-019 SHALL increment occupancy on an accept, decrement it on fifo_ovalid, and leave it unchanged when both occur in the same cycle.
REQ-020 SHALL never decrement occupancy below 0; a fifo_ovalid pulse at occupancy 0 is ignored.
REQ-021 SHALL update grant_id only on an accept.
REQ-022 SHALL keep req_ready all-zero when full is high, including the cycle in which fifo_ovalid arrives; the freed slot becomes usable in the next cycle.
REQ-023 SHALL keep req_ready[i] low while req_valid[i] is low.

Reset
REQ-024 SHALL, when reset=0 at a rising edge, set fifo_ivalid=0, fifo_idata=0, occupancy=0, full=0, grant_id=N-1 (so requester 0 has first priority), and the state machine to IDLE.
REQ-025 SHALL drop a beat accepted in the cycle reset is asserted; no fifo_ivalid is issued for it.
REQ-026 SHALL hold req_ready all-zero while reset=0.

Configuration
REQ-027 SHALL, with FIFO_ARB_PKT_LOCK_EN defined, implement states IDLE and LOCKED:
- IDLE -> LOCKED on an accept with req_last=0.
- In LOCKED, arbitration is suppressed and only the locked requester can be accepted.
- LOCKED -> IDLE on an accept with req_last=1.
- An accept with req_last=1 in IDLE stays in IDLE.
REQ-028 SHALL, without FIFO_ARB_PKT_LOCK_EN, ignore req_last, omit the LOCKED state and re-arbitrate on every beat.

Structure
REQ-029 SHALL import a shared package mpi_pkg holding the FIFO defaults (W=128, D=8), the arbiter state enum (IDLE, LOCKED) and a function returning the occupancy cap 2**D-1.
REQ-030 SHALL instantiate one sub-module rr_arbiter (N-bit request, one-hot grant, rotating priority pointer); occupancy tracking and the state machine remain in fifo_wr_arbiter.

Verification
REQ-031 SHALL cover: req_valid=4'b1111 held continuously with ivalid-only FIFO -> accepts in order 0,1,2,3,0; fifo_ivalid high every cycle from cycle 1.
REQ-032 SHALL cover: D=3, no pops, requester 2 streaming -> exactly 7 accepts, then full=1 and req_ready=0; one fifo_ovalid pulse -> exactly one further accept, in the following cycle.
REQ-033 SHALL cover: accept and fifo_ovalid in the same cycle at occupancy 5 -> occupancy stays 5.
REQ-034 SHALL cover: FIFO_ARB_PKT_LOCK_EN defined, requester 1 sends 3 beats with last on the 3rd while requester 0 is valid -> beats 1,1,1 then 0; without the macro -> 1,0,1,0.
REQ-035 SHALL cover: reset=0 asserted mid-stream at occupancy 4 -> next cycle occupancy=0, fifo_ivalid=0, grant_id=N-1.
